// File: rtl/uart_tx_arbiter.sv
// 8N1 UART transmitter shared by NUM_REQ byte streams: round-robin grant with packet locking.
// Frame = 10*CLKS_PER_BIT cycles from the accept edge; req_ready only in IDLE (one IDLE cycle between frames).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 locked
);
  localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int TMO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int TMO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [2:0]        rr_ptr;
  logic [2:0]        owner;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              baud_done;
  logic              owner_vld;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic [7:0]        win_data;
  logic              win_last;

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    if (int'(p) + 1 >= NUM_REQ) return 3'd0;
    return p + 3'd1;
  endfunction

  function automatic int rot_idx(input logic [2:0] p, input int k);
    int r;
    r = int'(p) + k;
    if (r >= NUM_REQ) r = r - NUM_REQ;
    return r;
  endfunction

  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);

  // Arbitration: scan downwards so the requester closest to rr_ptr is assigned last and wins.
  always_comb begin
    owner_vld = 1'b0;
    win_vld   = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    win_last  = 1'b0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (3'(j) == owner) owner_vld = req_valid[j];
    if (state == IDLE && reset) begin
      if (locked) begin
        win_vld = owner_vld;
        win_idx = owner;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--)
          for (int j = 0; j < NUM_REQ; j++)
            if (j == rot_idx(rr_ptr, k) && req_valid[j]) begin
              win_vld = 1'b1;
              win_idx = 3'(j);
            end
      end
    end
    for (int j = 0; j < NUM_REQ; j++)
      if (3'(j) == win_idx) begin
        win_data     = req_data[8*j +: 8];
        win_last     = req_last[j];
        req_ready[j] = win_vld;
      end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    uart_tx   = 1'b1;
    case (state)
      IDLE:  if (win_vld) state_nxt = START;
      START: begin
        uart_tx = 1'b0;
        if (baud_done) state_nxt = DATA;
      end
      DATA: begin
        uart_tx = shreg[bit_cnt];
        if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      end
      STOP:    if (baud_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + BAUD_W'(1);
      if (state == DATA && baud_done) bit_cnt <= bit_cnt + 3'd1;

      if (win_vld) begin
        shreg    <= win_data;
        grant_id <= win_idx;
        tmo_cnt  <= '0;
        if (win_last) begin
          locked <= 1'b0;
          rr_ptr <= wrap_inc(win_idx);
        end else begin
          locked <= 1'b1;
          owner  <= win_idx;
        end
      end else if (locked && owner_vld) begin
        tmo_cnt <= '0;
      end else if (LOCK_TIMEOUT > 0 && locked && state == IDLE) begin
        // An owner that stalls mid-packet must not starve the other streams forever.
        if (tmo_cnt == TMO_W'(TMO_LAST)) begin
          locked  <= 1'b0;
          rr_ptr  <= wrap_inc(owner);
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N   = 2;
  localparam int CPB = 4;
  localparam int TMO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           uart_tx;
  logic           busy;
  logic [2:0]     grant_id;
  logic           locked;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int aborts = 0;
  int pushed = 0;
  logic [10:0] exp_q[$];

  int          rr_ord [4] = '{0, 1, 0, 1};
  logic [7:0]  rr_byte[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_tx(uart_tx), .busy(busy),
    .grant_id(grant_id), .locked(locked)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial decoder: samples each bit in its middle cycle and compares against the scoreboard.
  initial begin : monitor
    logic [7:0]  b;
    logic [2:0]  g;
    logic        st, sp, ab;
    logic [10:0] e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        ab = 1'b0; b = '0; g = '0; st = 1'b1; sp = 1'b0;
        for (int c = 1; c <= 38; c++) begin
          @(negedge clock);
          if (reset !== 1'b1) begin ab = 1'b1; break; end
          if (c == 2) begin st = uart_tx; g = grant_id; end
          else if (c == 38) sp = uart_tx;
          else if (c >= 6 && (c - 2) % 4 == 0) b = {uart_tx, b[7:1]};
        end
        if (ab) aborts++;
        else begin
          frames++;
          check("start_bit", int'(st), 0);
          check("stop_bit", int'(sp), 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", int'(b), int'(e[7:0]));
            check("frame_grant", int'(g), int'(e[10:8]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 300us");
    $fatal(1);
  end

  task automatic accept_now(input int id, input logic [7:0] d, input bit push);
    check("idle_line_high", int'(uart_tx), 1);
    if (push) begin exp_q.push_back({3'(id), d}); pushed++; end
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
    @(negedge clock);
    check("start_after_accept", int'(uart_tx), 0);
    check("busy_in_frame", int'(busy), 1);
    check("grant_id", int'(grant_id), id);
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic l, input bit push);
    bit got;
    got = 1'b0;
    @(posedge clock); #1;
    req_data[8*id +: 8] = d;
    req_last[id]        = l;
    req_valid[id]       = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: req%0d ready stayed 0, expected grant within 200 cycles", id);
      req_valid[id] = 1'b0;
    end else begin
      accept_now(id, d, push);
    end
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (!busy) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stayed 1, expected IDLE within 100 cycles");
    end
  endtask

  initial begin : stim
    int k;
    bit got;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_ready", int'(req_ready), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Single byte, then measure when the next accept becomes possible.
    send(0, 8'h55, 1'b1, 1'b1);
    req_data[15:8] = 8'h66; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    k = 1; got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock); k++;
      if (req_ready[1]) begin got = 1'b1; break; end
    end
    check("ready_reassert_cycles", k, 41);
    if (got) accept_now(1, 8'h66, 1'b1);

    // Round robin with both requesters continuously valid.
    req_data = {8'h22, 8'h11}; req_last = 2'b11; req_valid = 2'b11;
    for (int a = 0; a < 4; a++) begin
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clock);
        if (req_ready != '0) begin got = 1'b1; break; end
      end
      check("rr_ready_onehot", int'(req_ready), 1 << rr_ord[a]);
      if (!got) break;
      exp_q.push_back({3'(rr_ord[a]), rr_byte[a]}); pushed++;
      @(posedge clock); #1;
      if (a < 2) req_data[8*rr_ord[a] +: 8] = rr_byte[a+2];
      else       req_valid[rr_ord[a]] = 1'b0;
      @(negedge clock);
      check("rr_grant", int'(grant_id), rr_ord[a]);
    end
    req_valid = '0;

    // Packet lock: req1 waits until req0's packet ends.
    req_data[15:8] = 8'h77; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    send(0, 8'h48, 1'b0, 1'b1);
    check("locked_after_last0", int'(locked), 1);
    wait_idle();
    check("locked_idle_ready", int'(req_ready), 0);
    send(0, 8'h0A, 1'b1, 1'b1);
    check("unlocked_after_last1", int'(locked), 0);
    send(1, 8'h77, 1'b1, 1'b1);

    // Lock timeout: owner goes quiet mid-packet.
    send(0, 8'hC3, 1'b0, 1'b1);
    req_data[15:8] = 8'h3C; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    wait_idle();
    check("tmo_locked_at_idle", int'(locked), 1);
    k = 1; got = req_ready[1];
    while (!got && k < 60) begin
      @(negedge clock); k++;
      got = req_ready[1];
    end
    check("tmo_grant_idle_cycle", k, 17);
    check("tmo_unlocked", int'(locked), 0);
    if (got) accept_now(1, 8'h3C, 1'b1);

    // Reset during data bit 3 of 0xA5 (bit value 0), lock held by req1.
    send(1, 8'hA5, 1'b0, 1'b0);
    repeat (17) @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_uart_tx", int'(uart_tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_grant", int'(grant_id), 0);
    check("midrst_ready", int'(req_ready), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    send(0, 8'h5A, 1'b1, 1'b1);

    // Data changed after the accept edge must not reach the line.
    send(1, 8'h3E, 1'b1, 1'b1);
    repeat (6) @(negedge clock);
    req_data[15:8] = 8'hE7;

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    check("frames_decoded", frames, pushed);
    check("frames_aborted", aborts, 1);
    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Synthesizable UART transmit scheduler.
- Shares one 8N1 serial TX line between NUM_REQ byte-stream requesters, e.g. the core console and a trace/debug stream.
- Round-robin arbitration with packet locking, so lines from different requesters never interleave mid-message.
- Sits between SoC byte producers and the io_uart_tx pin observed by the testbench tty model.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2.
- LOCK_TIMEOUT, 4096, idle cycles after which a held packet lock is dropped; 0 = never drop.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte ends the requester's packet; releases the lock.
- req_ready  out  NUM_REQ  one-hot accept; a byte transfers on valid&ready.
- uart_tx  out  1  serial output; idles high.
- busy  out  1  frame in progress (any state other than IDLE).
- grant_id  out  3  index of the requester owning the current or last frame.
- locked  out  1  packet lock held.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Next cycle: uart_tx=1, req_ready=0, busy=0, grant_id=0, locked=0, rr_ptr=0, state=IDLE, bit and baud counters=0.
  - Reset mid-frame aborts the frame immediately; no partial byte is resumed.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational from the registered lock/rr_ptr and from req_valid; at most one bit is set.
  - Unlocked: winner is the first valid requester scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Locked: only the owner can be granted; other requesters see ready=0 even when valid.
  - When req_valid[w]&req_ready[w]: latch the byte, set grant_id=w, go to START.
  - If req_last[w]=1: locked=0 and rr_ptr=(w+1) mod NUM_REQ.
  - If req_last[w]=0: locked=1, owner=w, rr_ptr unchanged.
- START: uart_tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; the bit counter wraps 7→0 on exit.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - If a byte is accepted at edge T, uart_tx falls at T+1.
  - The frame lasts exactly 10*CLKS_PER_BIT cycles.
  - The earliest next accept is the edge at T+1+10*CLKS_PER_BIT.
  - Back-to-back bytes produce one stop bit with no extra idle gap beyond the one IDLE cycle.
- req_ready is 0 in every state other than IDLE; busy=1 in START, DATA and STOP.
- Lock timeout:
  - Applies when LOCK_TIMEOUT>0, locked=1, state=IDLE and the owner's req_valid=0.
  - A counter increments on each such cycle and clears on any accept or when the owner's valid is high.
  - When the counter reaches LOCK_TIMEOUT: locked=0, rr_ptr=(owner+1) mod NUM_REQ, counter=0.
  - Other requesters become eligible from the following cycle.
- Inputs are ignored outside the accepting edge. Changing req_data while ready=0 has no effect.
- NUM_REQ=1: arbitration degenerates; lock and timeout remain legal but have no effect on grant.

Test Plan (CLKS_PER_BIT=4, LOCK_TIMEOUT=16, NUM_REQ=2):
- Reset, then req0 sends 0x55 with last=1 → uart_tx=1 until the cycle after accept, then bit sequence 0,1,0,1,0,1,0,1,0,1 each 4 cycles; ready re-asserts 41 cycles after the accept edge.
- req0 and req1 valid together, all bytes last=1, rr_ptr=0 → accept order req0, req1, req0, req1; grant_id toggles each frame.
- req0 sends 0x48 with last=0 while req1 is valid → locked=1, req1 ready stays 0; req0 then sends 0x0A with last=1 → req1 is granted next; serial shows 0x48, 0x0A, then req1's byte.
- req0 sends a last=0 byte, then drops valid while req1 is valid → after 16 idle cycles in IDLE, locked=0 and req1 is granted on the next cycle.
- reset asserted low during DATA bit 3 of 0xA5 → uart_tx=1 and busy=0 the next cycle; after release the next frame starts clean with a start bit.
- req_data changed while busy, before the next accept → the transmitted byte equals the value latched at the accept edge.
